flash_port_arbiter: RTL and testbench

- Shares the single Flash32 internal request port among `NREQ` requesters.
- Arbitration is round-robin, with an optional lock so one requester can run a multi-write sequence (play buffer + SPI control register) without interleaving.
- Read responses (`DRDY`/`DTO`/`TAGO`) are routed back to the issuing requester using an in-order outstanding-read FIFO.
- Sits between the core-side bus masters (CPU, DMA, debug) and the flash/RAM-BIOS controller.

---
 rtl/flash_arb_pkg.sv | 10 +
 rtl/flash_arb_idfifo.sv | 60 ++++++
 rtl/flash_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_flash_port_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// Shared constants for the Flash32 request-port arbiter and its helpers.
package flash_arb_pkg;

    localparam int MAX_NREQ = 8;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int TAG_W    = 21;
    localparam int BE_W     = 8;

endpackage

// File: rtl/flash_arb_idfifo.sv
// Small in-order FIFO of requester indices, used to route read responses
// back to whoever issued the read.
module flash_arb_idfifo #(
    parameter int DEPTH = 4,
    parameter int IDW   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic [IDW-1:0] push_id,
    input  logic           pop,
    output logic           full,
    output logic           empty,
    output logic [IDW-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [IDW-1:0] mem_q [DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           doPush;
    logic           doPop;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign head   = mem_q[rptr_q];
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (doPush) wptr_d = wptr_q + 1'b1;
        if (doPop)  rptr_d = rptr_q + 1'b1;
        if (doPush && !doPop)      count_d = count_q + 1'b1;
        else if (!doPush && doPop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wptr_q] <= push_id;
    end

endmodule

// File: rtl/flash_port_arbiter.sv
// Round-robin arbiter with optional lock sharing the single Flash32 request
// port; read responses are steered back to the issuer in order.
module flash_port_arbiter
    import flash_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DEPTH = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                   CLKH,
    input  logic                   RESET,
    output logic [IDW-1:0]         OWNER,
    output logic                   LOCKED,
    output logic                   ERR,

    input  logic [NREQ-1:0]        RACT,
    input  logic [NREQ-1:0]        RCMD,
    input  logic [NREQ-1:0]        RLOCK,
    input  logic [NREQ*ADDR_W-1:0] RADDR,
    input  logic [NREQ*BE_W-1:0]   RBE,
    input  logic [NREQ*DATA_W-1:0] RDTI,
    input  logic [NREQ*TAG_W-1:0]  RTAGI,
    output logic [NREQ-1:0]        RNEXT,
    output logic [NREQ-1:0]        RDRDY,
    output logic [DATA_W-1:0]      RDTO,
    output logic [TAG_W-1:0]       RTAGO,

    input  logic                   NEXT,
    output logic                   ACT,
    output logic                   CMD,
    output logic [ADDR_W-1:0]      ADDR,
    output logic [BE_W-1:0]        BE,
    output logic [DATA_W-1:0]      DTI,
    output logic [TAG_W-1:0]       TAGI,
    input  logic                   DRDY,
    input  logic [DATA_W-1:0]      DTO,
    input  logic [TAG_W-1:0]       TAGO
);

    logic [IDW-1:0] owner_q, owner_d;
    logic           locked_q, locked_d;
    logic           err_q, err_d;
    logic [IDW-1:0] sel;
    logic           valid;
    logic           stall;
    logic           accept;
    logic           fifoFull;
    logic           fifoEmpty;
    logic [IDW-1:0] fifoHead;
    logic           respPop;

    // Lowest rotating offset from OWNER wins, so scan offsets high-to-low.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        idx   = 0;
        cand  = '0;
        sel   = owner_q;
        valid = 1'b0;
        if (locked_q) begin
            valid = RACT[owner_q];
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx  = (int'(owner_q) + k) % NREQ;
                cand = IDW'(idx);
                if (RACT[cand]) begin
                    sel   = cand;
                    valid = 1'b1;
                end
            end
        end
    end

    assign stall  = RCMD[sel] & fifoFull;
    assign ACT    = valid & ~stall;
    assign accept = ACT & NEXT;

    always_comb begin
        CMD   = 1'b0;
        ADDR  = '0;
        BE    = '0;
        DTI   = '0;
        TAGI  = '0;
        RNEXT = '0;
        if (valid) begin
            CMD  = RCMD[sel];
            ADDR = RADDR[int'(sel)*ADDR_W +: ADDR_W];
            BE   = RBE[int'(sel)*BE_W +: BE_W];
            DTI  = RDTI[int'(sel)*DATA_W +: DATA_W];
            TAGI = RTAGI[int'(sel)*TAG_W +: TAG_W];
        end
        RNEXT[sel] = accept;
    end

    always_comb begin
        owner_d  = owner_q;
        locked_d = locked_q;
        err_d    = err_q | (DRDY & fifoEmpty);
        if (accept) begin
            if (RLOCK[sel]) begin
                locked_d = 1'b1;
                owner_d  = sel;
            end else begin
                locked_d = 1'b0;
                owner_d  = (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
            end
        end
    end

    always_ff @(posedge CLKH or negedge RESET) begin
        if (!RESET) begin
            owner_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    // Responses are gated by a non-empty FIFO so stale DRDYs only raise ERR.
    assign respPop = DRDY & ~fifoEmpty;

    always_comb begin
        RDRDY = '0;
        for (int i = 0; i < NREQ; i++) begin
            RDRDY[i] = respPop & (fifoHead == IDW'(i));
        end
    end

    flash_arb_idfifo #(
        .DEPTH (DEPTH),
        .IDW   (IDW)
    ) u_idfifo (
        .clk     (CLKH),
        .rst_n   (RESET),
        .push    (accept & RCMD[sel]),
        .push_id (sel),
        .pop     (respPop),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .head    (fifoHead)
    );

    assign RDTO   = DTO;
    assign RTAGO  = TAGO;
    assign OWNER  = owner_q;
    assign LOCKED = locked_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Directed table-driven bench for flash_port_arbiter with NREQ=4, DEPTH=4,
// plus a hand-written asynchronous reset sequence.
module tb_flash_port_arbiter;

    localparam int NREQ = 4;

    logic          CLKH;
    logic          RESET;
    logic [1:0]    OWNER;
    logic          LOCKED;
    logic          ERR;
    logic [3:0]    RACT, RCMD, RLOCK;
    logic [127:0]  RADDR;
    logic [31:0]   RBE;
    logic [255:0]  RDTI;
    logic [83:0]   RTAGI;
    logic [3:0]    RNEXT, RDRDY;
    logic [63:0]   RDTO;
    logic [20:0]   RTAGO;
    logic          NEXT, ACT, CMD;
    logic [31:0]   ADDR;
    logic [7:0]    BE;
    logic [63:0]   DTI;
    logic [20:0]   TAGI;
    logic          DRDY;
    logic [63:0]   DTO;
    logic [20:0]   TAGO;

    int total = 0;
    int bad   = 0;
    int curVec = 0;

    typedef struct {
        logic [3:0] ract;
        logic [3:0] rcmd;
        logic [3:0] rlock;
        logic       next;
        logic       drdy;
        int         esel;
        logic       eact;
        logic [3:0] ernext;
        logic [3:0] erdrdy;
        logic [1:0] eowner;
        logic       elocked;
        logic       eerr;
    } vec_t;

    vec_t vecs[$];

    flash_port_arbiter #(.NREQ(4), .DEPTH(4)) dut (
        .CLKH(CLKH), .RESET(RESET), .OWNER(OWNER), .LOCKED(LOCKED), .ERR(ERR),
        .RACT(RACT), .RCMD(RCMD), .RLOCK(RLOCK), .RADDR(RADDR), .RBE(RBE),
        .RDTI(RDTI), .RTAGI(RTAGI), .RNEXT(RNEXT), .RDRDY(RDRDY), .RDTO(RDTO),
        .RTAGO(RTAGO), .NEXT(NEXT), .ACT(ACT), .CMD(CMD), .ADDR(ADDR), .BE(BE),
        .DTI(DTI), .TAGI(TAGI), .DRDY(DRDY), .DTO(DTO), .TAGO(TAGO)
    );

    initial CLKH = 1'b0;
    always #5 CLKH = ~CLKH;

    function automatic logic [31:0] addrOf(int i);
        return 32'hA000_0000 + 32'(i) * 32'h100;
    endfunction
    function automatic logic [7:0] beOf(int i);
        return 8'hFF ^ (8'h01 << i);
    endfunction
    function automatic logic [63:0] dtiOf(int i);
        return {32'hCAFE_0000 + 32'(i), 32'h0BAD_0000 + 32'(i)};
    endfunction
    function automatic logic [20:0] tagOf(int i);
        return 21'h10000 + 21'(i);
    endfunction

    // Expected controller-side payload {CMD,ADDR,BE,DTI,TAGI}.
    function automatic logic [125:0] busOf(int i, logic [3:0] rcmd);
        if (i < 0) return '0;
        return {rcmd[i], addrOf(i), beOf(i), dtiOf(i), tagOf(i)};
    endfunction

    function automatic vec_t mk(logic [3:0] ract, logic [3:0] rcmd, logic [3:0] rlock,
                                logic next, logic drdy, int esel, logic eact,
                                logic [3:0] ernext, logic [3:0] erdrdy, logic [1:0] eowner,
                                logic elocked, logic eerr);
        vec_t v;
        v.ract = ract; v.rcmd = rcmd; v.rlock = rlock; v.next = next; v.drdy = drdy;
        v.esel = esel; v.eact = eact; v.ernext = ernext; v.erdrdy = erdrdy;
        v.eowner = eowner; v.elocked = elocked; v.eerr = eerr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s vec=%0d got=%0h want=%0h", name, curVec, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge CLKH);
        curVec = idx;
        RACT  = v.ract;
        RCMD  = v.rcmd;
        RLOCK = v.rlock;
        NEXT  = v.next;
        DRDY  = v.drdy;
        DTO   = {32'hD7D7_0000, 32'(idx)};
        TAGO  = 21'(idx * 3 + 1);
        #1;
        checkOutput("act",    256'(ACT),    256'(v.eact));
        checkOutput("rnext",  256'(RNEXT),  256'(v.ernext));
        checkOutput("rdrdy",  256'(RDRDY),  256'(v.erdrdy));
        checkOutput("owner",  256'(OWNER),  256'(v.eowner));
        checkOutput("locked", 256'(LOCKED), 256'(v.elocked));
        checkOutput("err",    256'(ERR),    256'(v.eerr));
        checkOutput("bus",    256'({CMD, ADDR, BE, DTI, TAGI}), 256'(busOf(v.esel, v.rcmd)));
        checkOutput("rdto",   256'(RDTO),   256'({32'hD7D7_0000, 32'(idx)}));
        checkOutput("rtago",  256'(RTAGO),  256'(21'(idx * 3 + 1)));
    endtask

    initial begin
        RESET = 1'b0;
        RACT = '0; RCMD = '0; RLOCK = '0; NEXT = 1'b0; DRDY = 1'b0;
        DTO = '0; TAGO = '0;
        for (int i = 0; i < NREQ; i++) begin
            RADDR[i*32 +: 32] = addrOf(i);
            RBE[i*8 +: 8]     = beOf(i);
            RDTI[i*64 +: 64]  = dtiOf(i);
            RTAGI[i*21 +: 21] = tagOf(i);
        end

        //                ract     rcmd     rlock   nx dr  sel act rnext    rdrdy   own  lk err
        // reset state and round-robin over writes
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1, 0, -1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0,  0, 1, 4'b0001, 4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd1, 0, 0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0,  2, 1, 4'b0100, 4'b0000, 2'd2, 0, 0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0,  3, 1, 4'b1000, 4'b0000, 2'd3, 0, 0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 1, 0,  0, 1, 4'b0001, 4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 0, 0,  1, 1, 4'b0000, 4'b0000, 2'd1, 0, 0));
        // lock sequence by requester 1, then lock held while its RACT is low
        vecs.push_back(mk(4'b0111, 4'b0000, 4'b0010, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd1, 0, 0));
        vecs.push_back(mk(4'b0111, 4'b0000, 4'b0010, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd1, 1, 0));
        vecs.push_back(mk(4'b0111, 4'b0000, 4'b0000, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd1, 1, 0));
        vecs.push_back(mk(4'b0101, 4'b0000, 4'b0000, 1, 0,  2, 1, 4'b0100, 4'b0000, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0010, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd3, 0, 0));
        vecs.push_back(mk(4'b0101, 4'b0000, 4'b0000, 1, 0, -1, 0, 4'b0000, 4'b0000, 2'd1, 1, 0));
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0000, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd1, 1, 0));
        // read routing: req3 then req0, responses in order
        vecs.push_back(mk(4'b1000, 4'b1000, 4'b0000, 1, 0,  3, 1, 4'b1000, 4'b0000, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1, 0,  0, 1, 4'b0001, 4'b0000, 2'd0, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1, 0, -1, 0, 4'b0000, 4'b0000, 2'd1, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1, 1, -1, 0, 4'b0000, 4'b1000, 2'd1, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1, 1, -1, 0, 4'b0000, 4'b0001, 2'd1, 0, 0));
        // fill FIFO with four reads from req1, fifth stalls
        vecs.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd1, 0, 0));
        vecs.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1, 0,  1, 0, 4'b0000, 4'b0000, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0110, 4'b0010, 4'b0000, 1, 0,  2, 1, 4'b0100, 4'b0000, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0000, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd3, 0, 0));
        vecs.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1, 1,  1, 0, 4'b0000, 4'b0010, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0010, 4'b0010, 4'b0000, 1, 0,  1, 1, 4'b0010, 4'b0000, 2'd2, 0, 0));
        // drain, then a spurious response sets sticky ERR
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1, 1, -1, 0, 4'b0000, 4'b0010, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1, 1, -1, 0, 4'b0000, 4'b0010, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1, 1, -1, 0, 4'b0000, 4'b0010, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1, 1, -1, 0, 4'b0000, 4'b0010, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1, 1, -1, 0, 4'b0000, 4'b0000, 2'd2, 0, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1, 0, -1, 0, 4'b0000, 4'b0000, 2'd2, 0, 1));

        repeat (2) @(negedge CLKH);
        RESET = 1'b1;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Two locked reads from req0 outstanding, then asynchronous reset.
        curVec = 100;
        @(negedge CLKH);
        RACT = 4'b0001; RCMD = 4'b0001; RLOCK = 4'b0001; NEXT = 1'b1; DRDY = 1'b0;
        #1;
        checkOutput("rd1_rnext", 256'(RNEXT), 256'(4'b0001));
        @(negedge CLKH);
        #1;
        checkOutput("rd2_locked", 256'(LOCKED), 256'(1'b1));
        checkOutput("rd2_rnext",  256'(RNEXT),  256'(4'b0001));
        @(negedge CLKH);
        RACT = 4'b0000;
        #1;
        checkOutput("pre_rst_owner", 256'(OWNER), 256'(2'd0));
        checkOutput("pre_rst_err",   256'(ERR),   256'(1'b1));
        #1;
        RESET = 1'b0;
        #1;
        checkOutput("rst_owner",  256'(OWNER),  256'(2'd0));
        checkOutput("rst_locked", 256'(LOCKED), 256'(1'b0));
        checkOutput("rst_err",    256'(ERR),    256'(1'b0));
        checkOutput("rst_act",    256'(ACT),    256'(1'b0));
        checkOutput("rst_rnext",  256'(RNEXT),  256'(4'b0000));
        checkOutput("rst_rdrdy",  256'(RDRDY),  256'(4'b0000));
        @(negedge CLKH);
        RESET = 1'b1;
        @(negedge CLKH);
        DRDY = 1'b1;
        #1;
        checkOutput("late_rdrdy", 256'(RDRDY), 256'(4'b0000));
        checkOutput("late_err0",  256'(ERR),   256'(1'b0));
        @(negedge CLKH);
        DRDY = 1'b0;
        #1;
        checkOutput("late_err1",  256'(ERR),   256'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
